gray_counter_param: RTL and testbench
=====================================

// Module: gray_counter_param
// PURPOSE
//   Parametrised up/down Gray-code counter. Generalises the 2-bit Gray FSM counter
//   to WIDTH bits and adds enable, direction, Gray-coded parallel load and a
//   terminal-count flag. Used as a pointer/sequence source where only one output
//   bit may change per step (e.g. clock-domain-crossing FIFO pointers).
// PARAMETERS
//   WIDTH    3   counter width in bits (>= 2)
//   RST_VAL  0   reset value, binary encoding (Gray output resets to its Gray image)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low (0 = reset)
//   en         in   1      count enable; advance one Gray step per clk when 1
//   up         in   1      direction: 1 = up (increment), 0 = down (decrement)
//   load       in   1      synchronous load of ld_gray
//   ld_gray    in   WIDTH  load value, Gray-coded
//   y          out  WIDTH  registered Gray-coded count
//   bin        out  WIDTH  registered binary equivalent of y
//   tc         out  1      terminal count, combinational: next enabled step wraps
// BEHAVIOUR
//   - State is a single WIDTH-bit binary register b.
//     bin = b; y is registered in the same edge as b, with y = b ^ (b >> 1) at all times.
//   - Reset (rst==0, async):
//     b <= RST_VAL; y <= RST_VAL ^ (RST_VAL>>1).
//     Release is sampled on the next rising clk; no count on the release edge if en==0.
//   - Priority at each rising edge: rst > load > en > hold.
//   - load==1: b <= gray2bin(ld_gray), where gray2bin(g)[i] = ^g[WIDTH-1:i];
//     y <= ld_gray. Load ignores en and up. Latency is 1 clk (visible the cycle after).
//   - en==1, load==0: b <= b+1 if up, b-1 if !up, modulo 2^WIDTH.
//     y changes by exactly one bit per step, including at the wrap.
//   - en==0, load==0: b and y hold.
//   - Wrap-around: up from 2^WIDTH-1 -> 0; down from 0 -> 2^WIDTH-1.
//     No saturation, no error flag.
//   - tc = en & ~load & (up ? (b == {WIDTH{1'b1}}) : (b == 0)).
//     Combinational, valid in the cycle before the wrapping edge.
//   - up may change on any cycle. The new direction takes effect on the next enabled edge.
//   - Simultaneous load & en: load wins; tc is forced 0.
//   - Reset asserted mid-count: outputs go to reset values immediately (asynchronous),
//     independent of clk. tc falls with them, except where the reset value itself
//     satisfies the tc condition.
//   - No X propagation: all outputs are defined from reset onward.
//   - All bin/y updates come from one always block, so y and bin never disagree.
// TESTING (WIDTH=3, RST_VAL=0, clk period 20)
//   1. rst=0 then release, en=1, up=1 for 9 clks
//      -> y = 000,001,011,010,110,111,101,100,000; bin = 0..7,0; tc=1 only while bin==7.
//   2. From y=000: en=1, up=0 for 3 clks
//      -> y = 100,101,111; tc=1 in the first cycle (bin==0); single-bit change at every step.
//   3. load=1, ld_gray=110, en=1 for 1 clk
//      -> y=110, bin=100, tc=0 during the load cycle; next up step -> y=111.
//   4. en=0 for 5 clks at y=011
//      -> y and bin hold at 011/010; tc=0 throughout.
//   5. Drop rst mid-count at y=101, between clock edges
//      -> y=000 and bin=000 before the next edge; counting resumes from 000 after release.
//   6. Random en/up/load for 1000 clks
//      -> checker confirms y == bin^(bin>>1), Hamming(y_prev, y) <= 1 on non-load edges,
//         and tc matches its equation.

Source files
------------

// File: rtl/gray_counter_param_if.sv
// Control and count bundle for gray_counter_param.
// master drives en/up/load/ld_gray and observes y/bin/tc.
interface gray_counter_param_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] ld_gray;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] bin;
  logic             tc;

  modport master (
    output en, up, load, ld_gray,
    input  y, bin, tc
  );

  modport slave (
    input  en, up, load, ld_gray,
    output y, bin, tc
  );
endinterface

// File: rtl/gray_counter_param.sv
// Up/down WIDTH-bit Gray counter with enable, Gray load and terminal count.
// Ports: clk, rst (async active-low), io (en, up, load, ld_gray -> y, bin, tc).
module gray_counter_param #(
  parameter int          WIDTH   = 3,
  parameter int unsigned RST_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  gray_counter_param_if.slave io
);

  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;

  function automatic logic [WIDTH-1:0] gray2bin(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] r;
    r[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

  always_comb begin
    b_d = b_q;
    if (io.load) begin
      b_d = gray2bin(io.ld_gray);
    end else if (io.en) begin
      if (io.up) b_d = b_q + WIDTH'(1);
      else       b_d = b_q - WIDTH'(1);
    end
    // Gray image of the next binary value; equals ld_gray on a load.
    y_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q <= RST_B;
      y_q <= RST_G;
    end else begin
      b_q <= b_d;
      y_q <= y_d;
    end
  end

  assign io.bin = b_q;
  assign io.y   = y_q;
  assign io.tc  = io.en & ~io.load &
                  (io.up ? (&b_q) : ~(|b_q));

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed and random-walk checks for gray_counter_param (WIDTH=3).
// Expected values come from hand tables and a small lookup model.
module tb_gray_counter_param;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  gray_counter_param_if #(.WIDTH(3)) bus ();

  gray_counter_param #(
    .WIDTH  (3),
    .RST_VAL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      if ((vv ^ (vv >> 1)) == g) r = vv;
    end
    return r;
  endfunction

  logic [2:0] gtab [8];
  logic [2:0] mb;
  logic [2:0] prev_y;
  logic       r_en, r_up, r_ld;
  logic [2:0] r_lg;
  int         exp_tc;

  initial begin
    gtab = '{3'b000, 3'b001, 3'b011, 3'b010,
             3'b110, 3'b111, 3'b101, 3'b100};
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.up = 1'b1;
    bus.load = 1'b0;
    bus.ld_gray = 3'b000;

    #5;
    chk("rst_y", int'(bus.y), 0);
    chk("rst_bin", int'(bus.bin), 0);
    chk("rst_tc", int'(bus.tc), 0);
    #10 rst = 1'b1;
    tick();
    chk("rel_y", int'(bus.y), 0);
    chk("rel_bin", int'(bus.bin), 0);

    // count up through a full wrap
    bus.en = 1'b1;
    bus.up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("up_y", int'(bus.y), int'(gtab[i]));
      chk("up_bin", int'(bus.bin), i);
      chk("up_tc", int'(bus.tc), (i == 7) ? 1 : 0);
      tick();
    end
    chk("wrap_y", int'(bus.y), 0);
    chk("wrap_bin", int'(bus.bin), 0);

    // count down through the low wrap
    bus.up = 1'b0;
    #1;
    chk("dn_tc0", int'(bus.tc), 1);
    tick();
    chk("dn_y1", int'(bus.y), 3'b100);
    chk("dn_bin1", int'(bus.bin), 7);
    chk("dn_tc1", int'(bus.tc), 0);
    tick();
    chk("dn_y2", int'(bus.y), 3'b101);
    chk("dn_bin2", int'(bus.bin), 6);
    tick();
    chk("dn_y3", int'(bus.y), 3'b111);
    chk("dn_bin3", int'(bus.bin), 5);

    // load with en asserted
    bus.up = 1'b1;
    bus.load = 1'b1;
    bus.ld_gray = 3'b110;
    #1;
    chk("ld_tc", int'(bus.tc), 0);
    tick();
    bus.load = 1'b0;
    chk("ld_y", int'(bus.y), 3'b110);
    chk("ld_bin", int'(bus.bin), 4);
    tick();
    chk("ld_next_y", int'(bus.y), 3'b111);

    // load forces tc low even at the terminal value
    bus.load = 1'b1;
    bus.ld_gray = 3'b100;
    tick();
    bus.load = 1'b0;
    #1;
    chk("ld7_bin", int'(bus.bin), 7);
    chk("ld7_tc", int'(bus.tc), 1);
    bus.load = 1'b1;
    bus.ld_gray = 3'b011;
    #1;
    chk("ldtc_forced", int'(bus.tc), 0);
    tick();
    bus.load = 1'b0;
    bus.en = 1'b0;

    // hold
    for (int i = 0; i < 5; i++) begin
      chk("hold_y", int'(bus.y), 3'b011);
      chk("hold_bin", int'(bus.bin), 2);
      chk("hold_tc", int'(bus.tc), 0);
      tick();
    end

    // async reset mid-count at y=101
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_y", int'(bus.y), 3'b101);
    #4 rst = 1'b0;
    #2;
    chk("arst_y", int'(bus.y), 0);
    chk("arst_bin", int'(bus.bin), 0);
    chk("arst_tc_up", int'(bus.tc), 0);
    bus.up = 1'b0;
    #1;
    chk("arst_tc_dn", int'(bus.tc), 1);
    bus.up = 1'b1;
    #5 rst = 1'b1;
    tick();
    chk("resume_y", int'(bus.y), 3'b001);
    chk("resume_bin", int'(bus.bin), 1);

    // random walk against the model
    mb = 3'd1;
    for (int n = 0; n < 1000; n++) begin
      r_en = 1'($urandom_range(0, 1));
      r_up = 1'($urandom_range(0, 1));
      r_ld = ($urandom_range(0, 7) == 0);
      r_lg = 3'($urandom_range(0, 7));
      bus.en = r_en;
      bus.up = r_up;
      bus.load = r_ld;
      bus.ld_gray = r_lg;
      #1;
      exp_tc = (r_en && !r_ld &&
               (r_up ? (mb == 3'd7) : (mb == 3'd0))) ? 1 : 0;
      chk("rnd_tc", int'(bus.tc), exp_tc);
      prev_y = bus.y;
      tick();
      if (r_ld) mb = g2b(r_lg);
      else if (r_en) mb = r_up ? mb + 3'd1 : mb - 3'd1;
      chk("rnd_bin", int'(bus.bin), int'(mb));
      chk("rnd_y", int'(bus.y), int'(mb ^ (mb >> 1)));
      if (!r_ld) begin
        chk("rnd_ham",
            ($countones(prev_y ^ bus.y) <= 1) ? 1 : 0, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
